// File: rtl/quadencoder_pkg.sv
// Constants shared by the quadrature encoder and its index-homing sequencer.
package quadencoder_pkg;

  localparam logic [1:0] IDX_IDLE    = 2'd0;
  localparam logic [1:0] IDX_ARM     = 2'd1;
  localparam logic [1:0] IDX_SEARCH  = 2'd2;
  localparam logic [1:0] IDX_RELEASE = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = IDX_IDLE,
    ST_ARM     = IDX_ARM,
    ST_SEARCH  = IDX_SEARCH,
    ST_RELEASE = IDX_RELEASE
  } idx_state_e;

  // Cycles indexenable is held low so the encoder drops its index-wait latch.
  localparam int RELEASE_CYCLES = 2;
  localparam int REL_W          = $clog2(RELEASE_CYCLES + 1);

  // Encoder handshake levels: indexout is high while the encoder waits for Z.
  localparam logic INDEX_WAIT_LVL  = 1'b1;
  localparam logic INDEX_ENABLE_ON = 1'b1;

endpackage

// File: rtl/quadencoder_timeout_cnt.sv
// Saturating up-counter with synchronous clear and enable. The match output
// flags count == limit-1. A limit of zero never matches.
module quadencoder_timeout_cnt #(
  parameter int W = 24
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] limit_i,
  output logic         match_o
);
  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i)
      count_d = '0;
    else if (en_i && (count_q != '1))
      count_d = count_q + W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign match_o = (limit_i != '0) && (count_q == (limit_i - W'(1)));

endmodule

// File: rtl/quadencoder_index_ctrl.sv
// Index-homing sequencer: IDLE -> ARM (wait indexout) -> SEARCH (wait Z) ->
// RELEASE (indexenable low) -> IDLE. Captures the pre-reset count on a hit.
module quadencoder_index_ctrl
  import quadencoder_pkg::*;
#(
  parameter int BITS         = 32,
  parameter int TIMEOUT_BITS = 24
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    arm,
  input  logic                    abort,
  input  logic [TIMEOUT_BITS-1:0] timeout,
  input  logic                    indexout,
  input  logic signed [BITS-1:0]  position,
  output logic                    indexenable,
  output logic                    busy,
  output logic                    done,
  output logic                    timed_out,
  output logic                    aborted,
  output logic                    homed,
  output logic signed [BITS-1:0]  latched_pos
);
  idx_state_e             state_q;
  logic [REL_W-1:0]       rel_q;
  logic signed [BITS-1:0] pos_prev_q, latched_q;
  logic ie_q, busy_q, done_q, timed_out_q, aborted_q, homed_q;
  logic cnt_clr, cnt_en, cnt_match, hit;

  assign cnt_clr = (state_q == ST_IDLE) && arm;
  assign cnt_en  = (state_q == ST_ARM) || (state_q == ST_SEARCH);
  assign hit     = (state_q == ST_SEARCH) && (indexout != INDEX_WAIT_LVL);

  quadencoder_timeout_cnt #(.W(TIMEOUT_BITS)) u_timeout_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (cnt_clr),
    .en_i    (cnt_en),
    .limit_i (timeout),
    .match_o (cnt_match)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      rel_q       <= '0;
      pos_prev_q  <= '0;
      latched_q   <= '0;
      ie_q        <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      timed_out_q <= 1'b0;
      aborted_q   <= 1'b0;
      homed_q     <= 1'b0;
    end else begin
      pos_prev_q  <= position;
      done_q      <= 1'b0;
      timed_out_q <= 1'b0;
      aborted_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (arm) begin
            state_q <= ST_ARM;
            ie_q    <= INDEX_ENABLE_ON;
            busy_q  <= 1'b1;
            homed_q <= 1'b0;
          end
        end
        ST_ARM, ST_SEARCH: begin
          // Priority: hit, then abort, then timeout; all three end in RELEASE.
          if (hit || abort || cnt_match) begin
            state_q <= ST_RELEASE;
            rel_q   <= REL_W'(RELEASE_CYCLES - 1);
            ie_q    <= ~INDEX_ENABLE_ON;
            if (hit) begin
              done_q    <= 1'b1;
              homed_q   <= 1'b1;
              latched_q <= pos_prev_q;
            end else if (abort) begin
              aborted_q <= 1'b1;
            end else begin
              timed_out_q <= 1'b1;
            end
          end else if ((state_q == ST_ARM) && (indexout == INDEX_WAIT_LVL)) begin
            state_q <= ST_SEARCH;
          end
        end
        ST_RELEASE: begin
          if (rel_q == '0) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else begin
            rel_q <= rel_q - REL_W'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign indexenable = ie_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign timed_out   = timed_out_q;
  assign aborted     = aborted_q;
  assign homed       = homed_q;
  assign latched_pos = latched_q;

endmodule

// File: tb/tb_quadencoder_index_ctrl.sv
// Self-checking bench: directed and random homing attempts against a
// trial-level model of event timing, plus a 4-bit counter saturation check.
module tb_quadencoder_index_ctrl;
  localparam int TW = 24;
  localparam int K_NONE = 0, K_HIT = 1, K_ABORT = 2, K_TO = 3;

  logic clk = 1'b0;
  logic rst_n, arm, abort, indexout;
  logic [TW-1:0] timeout;
  logic signed [31:0] position, latched_pos;
  logic indexenable, busy, done, timed_out, aborted, homed;

  logic s_arm, s_abort;
  logic [3:0] s_timeout;
  logic signed [31:0] s_latched;
  logic s_ie, s_busy, s_done, s_to, s_ab, s_homed;

  int checks = 0;
  int failures = 0;
  bit armed_already = 1'b0;
  bit prev_homed = 1'b0;
  logic signed [31:0] prev_latched = 0;

  always #5 clk = ~clk;

  quadencoder_index_ctrl #(.BITS(32), .TIMEOUT_BITS(TW)) dut (
    .clk(clk), .rst_n(rst_n), .arm(arm), .abort(abort), .timeout(timeout),
    .indexout(indexout), .position(position), .indexenable(indexenable),
    .busy(busy), .done(done), .timed_out(timed_out), .aborted(aborted),
    .homed(homed), .latched_pos(latched_pos)
  );

  quadencoder_index_ctrl #(.BITS(32), .TIMEOUT_BITS(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .arm(s_arm), .abort(s_abort), .timeout(s_timeout),
    .indexout(1'b0), .position(32'sd0), .indexenable(s_ie),
    .busy(s_busy), .done(s_done), .timed_out(s_to), .aborted(s_ab),
    .homed(s_homed), .latched_pos(s_latched)
  );

  task automatic check_eq(input string tag, input int cyc,
                          input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d act=%0h exp=%0h", tag, cyc, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One homing attempt. Cycle k=0 is the first cycle after the arm edge.
  // Event edges: hit z+1, abort a+1, timeout t_lim; earliest wins, ties by priority.
  task automatic run_trial(input int t_lim, input int r, input int z, input int a,
                           input bit force_pos, input int hit_pos, input bit hold);
    int e, kind, k0;
    logic signed [31:0] pos_v, cap_v;
    e = 1 << 30;
    kind = K_NONE;
    if (z >= 0) begin e = z + 1; kind = K_HIT; end
    if (a >= 0 && a + 1 < e) begin e = a + 1; kind = K_ABORT; end
    if (t_lim > 0 && t_lim < e) begin e = t_lim; kind = K_TO; end
    if (kind == K_NONE) begin a = 0; e = 1; kind = K_ABORT; end
    cap_v = 0;
    k0 = armed_already ? 0 : -1;
    for (int k = k0; k <= e + 2; k++) begin
      arm      = (k == -1) || hold;
      abort    = (k == a);
      indexout = (r >= 0) && (k >= r) && (z < 0 || k < z);
      timeout  = TW'(t_lim);
      if (z >= 0 && k >= z)          pos_v = 0;
      else if (force_pos && k >= 0)  pos_v = 32'(hit_pos * (k + 1) / z);
      else                           pos_v = $urandom;
      if (z >= 0 && k == z - 1) cap_v = pos_v;
      position = pos_v;
      @(negedge clk);
      check_eq("busy",        k, 32'(busy),        32'(k >= 0 && k <= e + 1));
      check_eq("indexenable", k, 32'(indexenable), 32'(k >= 0 && k < e));
      check_eq("done",        k, 32'(done),        32'(k == e && kind == K_HIT));
      check_eq("aborted",     k, 32'(aborted),     32'(k == e && kind == K_ABORT));
      check_eq("timed_out",   k, 32'(timed_out),   32'(k == e && kind == K_TO));
      check_eq("homed",       k, 32'(homed),
               32'(k < 0 ? prev_homed : (kind == K_HIT && k >= e)));
      check_eq("latched_pos", k, latched_pos,
               (kind == K_HIT && k >= e) ? cap_v : prev_latched);
      step();
    end
    prev_homed = (kind == K_HIT);
    if (kind == K_HIT) prev_latched = cap_v;
    armed_already = hold;
  endtask

  initial begin
    int t, r, z, a;
    rst_n = 1'b0; arm = 1'b0; abort = 1'b0; indexout = 1'b0;
    timeout = '0; position = 0;
    s_arm = 1'b0; s_abort = 1'b0; s_timeout = '0;
    repeat (3) step();
    @(negedge clk);
    check_eq("rst_busy",    0, 32'(busy),        0);
    check_eq("rst_ie",      0, 32'(indexenable), 0);
    check_eq("rst_pulses",  0, 32'({done, timed_out, aborted}), 0);
    check_eq("rst_homed",   0, 32'(homed),       0);
    check_eq("rst_latched", 0, latched_pos,      0);
    rst_n = 1'b1;
    step();

    run_trial(0,   3, 12,   -1,    1, 1234, 0);  // normal hit
    run_trial(100, 3, -1,   -1,    0, 0,    0);  // timeout at 100
    run_trial(0,   5, -1,   10000, 0, 0,    0);  // timeout disabled, abort
    run_trial(10,  2, 9,    9,     1, 555,  0);  // hit = abort = timeout edge
    run_trial(5,   -1, -1,  4,     0, 0,    0);  // abort beats timeout
    run_trial(0,   1, 6,    -1,    1, 77,   1);  // arm held across hit
    run_trial(0,   2, 7,    -1,    1, -7,   0);  // auto re-arm, negative capture

    // Reset while searching with position -500.
    arm = 1'b1; step();
    arm = 1'b0; indexout = 1'b1; position = -500; step();
    @(negedge clk);
    check_eq("pre_rst_busy", 1, 32'(busy), 1);
    step();
    rst_n = 1'b0; step();
    rst_n = 1'b1; indexout = 1'b0;
    @(negedge clk);
    check_eq("srst_ie",      3, 32'(indexenable), 0);
    check_eq("srst_busy",    3, 32'(busy),        0);
    check_eq("srst_pulses",  3, 32'({done, timed_out, aborted}), 0);
    check_eq("srst_homed",   3, 32'(homed),       0);
    check_eq("srst_latched", 3, latched_pos,      0);
    step();
    prev_homed = 1'b0; prev_latched = 0; armed_already = 1'b0;

    for (int i = 0; i < 40; i++) begin
      t = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 40));
      r = ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(0, 8));
      z = (r < 0 || $urandom_range(0, 3) == 0) ? -1 : r + int'($urandom_range(1, 30));
      a = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 40)) : -1;
      if (t == 0 && z < 0 && a < 0) a = int'($urandom_range(0, 40));
      run_trial(t, r, z, a, 0, 0, ($urandom_range(0, 5) == 0) && (i != 39));
    end

    // 4-bit counter: after saturation, a nonzero limit must never match.
    arm = 1'b0; abort = 1'b0;
    s_arm = 1'b1; step();
    s_arm = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      check_eq("sat_busy", k, 32'(s_busy), 1);
      step();
    end
    s_timeout = 4'd5;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      check_eq("sat_no_timeout", k, 32'(s_to), 0);
      step();
    end
    s_abort = 1'b1; step();
    s_abort = 1'b0;
    @(negedge clk);
    check_eq("sat_aborted", 0, 32'(s_ab),   1);
    check_eq("sat_to",      0, 32'(s_to),   0);
    check_eq("sat_ie",      0, 32'(s_ie),   0);
    check_eq("sat_homed",   0, 32'(s_homed), 0);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/quadencoder_index_ctrl.md
# quadencoder_index_ctrl

Index-homing sequencer for the quadrature encoder counter. It drives the counter's `indexenable` through one arm, search, hit and release cycle, so that the counter zeroes on the next Z pulse. On that hit it captures the pre-reset count, and it reports completion, abort or timeout to the host register interface. It sits between the host register file and one encoder instance, and owns that encoder's `indexenable` input.

## Interface

Parameters:
- `BITS`, default 32: width of the encoder position.
- `TIMEOUT_BITS`, default 24: width of the timeout counter and of the `timeout` port.

Ports (name, direction, width, meaning):
- `clk` input 1: the single clock, shared with the encoder.
- `rst_n` input 1: reset, synchronous, active-low.
- `arm` input 1: start an index search (level; acted on only in IDLE).
- `abort` input 1: cancel the search in progress.
- `timeout` input `TIMEOUT_BITS`: search limit in clk cycles; 0 disables the timeout.
- `indexout` input 1: from the encoder; high while the encoder waits for Z.
- `position` input `BITS` signed: from the encoder.
- `indexenable` output 1: to the encoder.
- `busy` output 1: high in every state except IDLE.
- `done` output 1: one-cycle pulse on an index hit.
- `timed_out` output 1: one-cycle pulse on a timeout.
- `aborted` output 1: one-cycle pulse on an abort.
- `homed` output 1: sticky; set on a hit, cleared on the next accepted `arm`.
- `latched_pos` output `BITS` signed: position immediately before the index reset.

## Operation

States:
- IDLE
  - `indexenable`=0.
  - `arm`=1 → ARM; clear `homed`; clear the timeout counter.
- ARM
  - `indexenable`=1.
  - `indexout`=1 → SEARCH.
- SEARCH
  - `indexenable`=1.
  - `indexout`=0 → hit, then RELEASE.
- RELEASE
  - `indexenable`=0 for exactly 2 cycles, so the encoder clears its index-wait latch.
  - Then → IDLE.

Position capture:
- `pos_prev` register samples `position` every cycle.
- On a hit, `latched_pos` ← `pos_prev`, i.e. the count in the last cycle `indexout` was 1, before the encoder zeroed it.
- The encoder does not count in its reset cycle, so `pos_prev` is exact.

Timeout:
- The counter increments every cycle spent in ARM or SEARCH.
- When `timeout`≠0 and counter == `timeout`−1 → `timed_out` pulse, then RELEASE.
- The counter saturates at all-ones. It never wraps.

Events and priority:
- Event priority in the same cycle: hit > abort > timeout.
- `abort` in ARM or SEARCH → `aborted` pulse, then RELEASE.
- `abort` in IDLE or RELEASE is ignored.
- `arm` is ignored when not in IDLE; it is never queued.
- `arm` held high re-arms automatically after RELEASE.
- `homed` and `latched_pos` are unchanged by abort and timeout.
- `timeout` is sampled every cycle, not latched at arm.

## Timing

- Reset values: all outputs 0, `latched_pos`=0, state IDLE, counter 0.
- `rst_n` low mid-search returns to IDLE and drops `indexenable` on the next edge.
- `arm` seen at edge N → `indexenable`=1 and `busy`=1 after edge N.
- A hit is detected at the edge where SEARCH sees `indexout`=0.
  - At that edge: `done`=1, `homed`=1, `latched_pos` valid; all three visible in the same cycle.
  - `indexenable` falls at that same edge.
- Pulses (`done`, `timed_out`, `aborted`) are exactly 1 cycle wide and mutually exclusive.
- `busy` stays high through both RELEASE cycles, then falls.
- Minimum arm-to-arm spacing is hit + 3 cycles.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure

- Package `quadencoder_pkg` holds:
  - the state encoding localparams (IDLE=0, ARM=1, SEARCH=2, RELEASE=3);
  - `RELEASE_CYCLES`=2.
- The encoder-side handshake constants live in `quadencoder_pkg` so the encoder and this block share them.
- One sub-module: `quadencoder_timeout_cnt`, a saturating up-counter with clear, enable and compare-equal output.
- The FSM, position capture and pulse logic stay in the top module.

## Test plan

- Normal hit:
  - Stimulus: `arm` pulse; encoder model raises `indexout` 3 cycles later; position ramps to 1234; `indexout` falls and position goes to 0.
  - Required: `done` pulse, `latched_pos`=1234, `homed`=1, `indexenable` low for 2 cycles, then IDLE.
- Timeout:
  - Stimulus: `timeout`=100, `arm`, no Z.
  - Required: `timed_out` exactly 100 cycles after entering ARM; `homed`=0; `latched_pos` unchanged.
- Timeout disabled:
  - Stimulus: `timeout`=0, 10000 cycles with no Z, then `abort`.
  - Required: `aborted` pulse; no `timed_out`; counter saturates without wrapping (force `TIMEOUT_BITS`=4).
- Simultaneous events:
  - Stimulus: hit, `abort` and timeout compare all in the same cycle.
  - Required: only `done` pulses; `latched_pos` updated.
- Re-arm and reset:
  - Stimulus: `arm` held high across a hit; separately, `rst_n` low in SEARCH with position −500.
  - Required (held `arm`): second ARM begins exactly 3 cycles after `done`, and `homed` clears.
  - Required (reset): all outputs 0 next cycle and `indexenable`=0.
- Negative capture:
  - Stimulus: position −7 at the hit.
  - Required: `latched_pos`=−7, sign-correct across the full `BITS` width.
